// File: rtl/pong_pkg.sv
// pong_pkg: game state encoding and default playfield geometry shared by the pong core
package pong_pkg;
  typedef enum logic [1:0] {SERVE, PLAY, POINT, GAME_OVER} state_t;
  localparam int NET_WIDTH = 3;
  localparam int DEF_COORD_W = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_BALL_SIZE = 6;
  localparam int DEF_BALL_SPEED = 4;
  localparam int DEF_PADDLE_WIDTH = 6;
  localparam int DEF_PADDLE_HEIGHT = 50;
  localparam int DEF_PADDLE1_HPOS = 10;
  localparam int DEF_PADDLE2_HPOS = 624;
  localparam int DEF_NET_HPOS = 320;
  localparam int DEF_SCORE_W = 4;
  localparam int DEF_SCORE_MAX = 9;
  localparam int DEF_SERVE_FRAMES = 60;
endpackage

// File: rtl/pong_renderer.sv
// pong_renderer: per-pixel hit tests for ball, paddles and net with a registered colour bit
module pong_renderer
  import pong_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int PADDLE_WIDTH = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int PADDLE1_HPOS = DEF_PADDLE1_HPOS,
  parameter int PADDLE2_HPOS = DEF_PADDLE2_HPOS,
  parameter int NET_HPOS = DEF_NET_HPOS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               de,
  input  logic [COORD_W-1:0] ball_hpos,
  input  logic [COORD_W-1:0] ball_vpos,
  input  logic               ball_show,
  input  logic [COORD_W-1:0] paddle1_vpos,
  input  logic [COORD_W-1:0] paddle2_vpos,
  output logic               pix
);
  localparam logic [COORD_W-1:0] BS = COORD_W'(BALL_SIZE);
  localparam logic [COORD_W-1:0] PW = COORD_W'(PADDLE_WIDTH);
  localparam logic [COORD_W-1:0] PH = COORD_W'(PADDLE_HEIGHT);
  localparam logic [COORD_W-1:0] P1 = COORD_W'(PADDLE1_HPOS);
  localparam logic [COORD_W-1:0] P2 = COORD_W'(PADDLE2_HPOS);
  localparam logic [COORD_W-1:0] NH = COORD_W'(NET_HPOS);
  localparam logic [COORD_W-1:0] NW = COORD_W'(NET_WIDTH);
  // wrap-around difference folds the lower and upper bound into one compare
  function automatic logic span(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] lo,
                                input logic [COORD_W-1:0] len);
    logic [COORD_W-1:0] d;
    d = p - lo;
    return d < len;
  endfunction
  logic gfx;
  assign gfx = (ball_show && span(hpos, ball_hpos, BS) && span(vpos, ball_vpos, BS))
    || (span(hpos, P1, PW) && span(vpos, paddle1_vpos, PH))
    || (span(hpos, P2, PW) && span(vpos, paddle2_vpos, PH))
    || (span(hpos, NH, NW) && !vpos[3]);
  always_ff @(posedge clk) pix <= reset ? 1'b0 : de && gfx;
endmodule

// File: rtl/pong_engine.sv
// pong_engine: frame-stepped pong game with scoring and serve/point/game-over flow
module pong_engine
  import pong_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int BALL_SPEED = DEF_BALL_SPEED,
  parameter int PADDLE_WIDTH = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int PADDLE1_HPOS = DEF_PADDLE1_HPOS,
  parameter int PADDLE2_HPOS = DEF_PADDLE2_HPOS,
  parameter int NET_HPOS = DEF_NET_HPOS,
  parameter int SCORE_W = DEF_SCORE_W,
  parameter int SCORE_MAX = DEF_SCORE_MAX,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               start,
  input  logic [COORD_W-1:0] paddle1_next,
  input  logic [COORD_W-1:0] paddle2_next,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               de,
  output logic               r,
  output logic               g,
  output logic               b,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over
);
  localparam int W1 = COORD_W + 1;
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [COORD_W:0] BS = W1'(BALL_SIZE);
  localparam logic [COORD_W:0] SP = W1'(BALL_SPEED);
  localparam logic [COORD_W:0] PW = W1'(PADDLE_WIDTH);
  localparam logic [COORD_W:0] PH = W1'(PADDLE_HEIGHT);
  localparam logic [COORD_W:0] P1 = W1'(PADDLE1_HPOS);
  localparam logic [COORD_W:0] P2 = W1'(PADDLE2_HPOS);
  localparam logic [COORD_W:0] HA = W1'(H_ACTIVE);
  localparam logic [COORD_W:0] VA = W1'(V_ACTIVE);
  localparam logic [COORD_W-1:0] SPD = COORD_W'(BALL_SPEED);
  localparam logic [COORD_W-1:0] CX = COORD_W'(H_ACTIVE / 2);
  localparam logic [COORD_W-1:0] CY = COORD_W'(V_ACTIVE / 2);
  localparam logic [COORD_W-1:0] PMAX = COORD_W'(V_ACTIVE - PADDLE_HEIGHT);
  localparam logic [COORD_W-1:0] BMAX = COORD_W'(V_ACTIVE - BALL_SIZE);
  localparam logic [SCORE_W-1:0] SMAX = SCORE_W'(SCORE_MAX);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SERVE_FRAMES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] serve_cnt, serve_cnt_n;
  logic [COORD_W-1:0] ball_hpos, ball_vpos, ball_hpos_n, ball_vpos_n;
  logic [COORD_W-1:0] paddle1_vpos, paddle2_vpos;
  // dir_h: 1 = right, dir_v: 1 = down, scorer: 1 = right player took the last point
  logic dir_h, dir_v, dir_h_n, dir_v_n, scorer, scorer_n;
  logic [SCORE_W-1:0] score1_n, score2_n;
  logic vsync_q, tick, hit1, hit2, miss_l, miss_r, bounce_d, bounce_u, pix;
  logic [COORD_W:0] bh, bv, p1, p2;
  assign tick = vsync & ~vsync_q;
  assign bh = {1'b0, ball_hpos};
  assign bv = {1'b0, ball_vpos};
  assign p1 = {1'b0, paddle1_vpos};
  assign p2 = {1'b0, paddle2_vpos};
  assign hit1 = !dir_h && bh <= P1 + PW && bh + BS > P1 && bv + BS > p1 && bv < p1 + PH;
  assign hit2 = dir_h && bh <= P2 + PW && bh + BS > P2 && bv + BS > p2 && bv < p2 + PH;
  assign miss_l = !dir_h && bh < SP;
  assign miss_r = dir_h && bh + BS + SP > HA;
  assign bounce_d = dir_v && bv + BS + SP > VA;
  assign bounce_u = !dir_v && bv < SP;
  assign game_over = state == GAME_OVER;
  always_comb begin
    state_n = state;
    serve_cnt_n = serve_cnt;
    ball_hpos_n = ball_hpos;
    ball_vpos_n = ball_vpos;
    dir_h_n = dir_h;
    dir_v_n = dir_v;
    score1_n = score1;
    score2_n = score2;
    scorer_n = scorer;
    case (state)
      SERVE: begin
        serve_cnt_n = serve_cnt == CNT_END ? '0 : serve_cnt + 1'b1;
        state_n = serve_cnt == CNT_END ? PLAY : SERVE;
      end
      PLAY:
        if (!hit1 && !hit2 && (miss_l || miss_r)) begin
          state_n = POINT;
          scorer_n = miss_l;
          score1_n = miss_r && score1 != SMAX ? score1 + 1'b1 : score1;
          score2_n = miss_l && score2 != SMAX ? score2 + 1'b1 : score2;
        end else begin
          dir_h_n = hit1 ? 1'b1 : hit2 ? 1'b0 : dir_h;
          ball_hpos_n = dir_h_n ? ball_hpos + SPD : ball_hpos - SPD;
          ball_vpos_n = bounce_d ? BMAX : bounce_u ? '0 : dir_v ? ball_vpos + SPD : ball_vpos - SPD;
          dir_v_n = bounce_d ? 1'b0 : bounce_u ? 1'b1 : dir_v;
        end
      POINT:
        if ((scorer ? score2 : score1) == SMAX) state_n = GAME_OVER;
        else begin
          state_n = SERVE;
          ball_hpos_n = CX;
          ball_vpos_n = CY;
          dir_h_n = !scorer;
        end
      GAME_OVER:
        if (start) begin
          state_n = SERVE;
          serve_cnt_n = '0;
          score1_n = '0;
          score2_n = '0;
          ball_hpos_n = CX;
          ball_vpos_n = CY;
          dir_h_n = 1'b1;
        end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SERVE;
      serve_cnt <= '0;
      ball_hpos <= CX;
      ball_vpos <= CY;
      dir_h <= 1'b1;
      dir_v <= 1'b1;
      scorer <= 1'b0;
      score1 <= '0;
      score2 <= '0;
      paddle1_vpos <= '0;
      paddle2_vpos <= '0;
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (tick) begin
        state <= state_n;
        serve_cnt <= serve_cnt_n;
        ball_hpos <= ball_hpos_n;
        ball_vpos <= ball_vpos_n;
        dir_h <= dir_h_n;
        dir_v <= dir_v_n;
        scorer <= scorer_n;
        score1 <= score1_n;
        score2 <= score2_n;
        paddle1_vpos <= paddle1_next > PMAX ? PMAX : paddle1_next;
        paddle2_vpos <= paddle2_next > PMAX ? PMAX : paddle2_next;
      end
    end
  end
  pong_renderer #(
    .COORD_W(COORD_W), .BALL_SIZE(BALL_SIZE), .PADDLE_WIDTH(PADDLE_WIDTH),
    .PADDLE_HEIGHT(PADDLE_HEIGHT), .PADDLE1_HPOS(PADDLE1_HPOS),
    .PADDLE2_HPOS(PADDLE2_HPOS), .NET_HPOS(NET_HPOS)
  ) u_renderer (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .de(de),
    .ball_hpos(ball_hpos), .ball_vpos(ball_vpos), .ball_show(state != GAME_OVER),
    .paddle1_vpos(paddle1_vpos), .paddle2_vpos(paddle2_vpos), .pix(pix)
  );
  assign r = pix;
  assign g = pix;
  assign b = pix;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: randomized frame-by-frame play checked against a behavioural game model
`timescale 1ns/1ps
module tb_pong_engine;
  import pong_pkg::*;
  localparam int BS = 6, SP = 4, PW = 6, PH = 50, P1X = 10, P2X = 624, NX = 320;
  localparam int HA = 640, VA = 480, SMAX = 9, SERVE_N = 60;
  logic clk = 0, reset = 1, vsync = 0, start = 0, de = 0;
  logic [9:0] paddle1_next = 0, paddle2_next = 0, hpos = 0, vpos = 0;
  logic r, g, b, game_over;
  logic [3:0] score1, score2;
  int vectors = 0, errors = 0;
  state_t ms;
  int cnt, bx, by, p1, p2, s1, s2;
  bit dh, dv, last_right;
  pong_engine dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start),
    .paddle1_next(paddle1_next), .paddle2_next(paddle2_next),
    .hpos(hpos), .vpos(vpos), .de(de), .r(r), .g(g), .b(b),
    .score1(score1), .score2(score2), .game_over(game_over)
  );
  always #5 clk = ~clk;
  function automatic void model_reset();
    ms = SERVE; cnt = 0; bx = HA / 2; by = VA / 2; dh = 1; dv = 1;
    p1 = 0; p2 = 0; s1 = 0; s2 = 0; last_right = 0;
  endfunction
  function automatic void model_tick(input int n1, input int n2, input bit st);
    bit h1, h2;
    case (ms)
      SERVE: begin
        cnt++;
        if (cnt == SERVE_N) begin ms = PLAY; cnt = 0; end
      end
      PLAY: begin
        h1 = !dh && bx <= P1X + PW && bx + BS > P1X && by + BS > p1 && by < p1 + PH;
        h2 = dh && bx <= P2X + PW && bx + BS > P2X && by + BS > p2 && by < p2 + PH;
        if (!h1 && !h2 && (dh ? bx + BS + SP > HA : bx < SP)) begin
          if (dh) s1 = s1 < SMAX ? s1 + 1 : s1;
          else s2 = s2 < SMAX ? s2 + 1 : s2;
          last_right = !dh;
          ms = POINT;
        end else begin
          if (h1) dh = 1;
          if (h2) dh = 0;
          bx += dh ? SP : -SP;
          if (dv && by + BS + SP > VA) begin by = VA - BS; dv = 0; end
          else if (!dv && by < SP) begin by = 0; dv = 1; end
          else by += dv ? SP : -SP;
        end
      end
      POINT:
        if ((last_right ? s2 : s1) >= SMAX) ms = GAME_OVER;
        else begin ms = SERVE; bx = HA / 2; by = VA / 2; dh = !last_right; end
      GAME_OVER:
        if (st) begin ms = SERVE; s1 = 0; s2 = 0; bx = HA / 2; by = VA / 2; dh = 1; cnt = 0; end
    endcase
    p1 = n1 > VA - PH ? VA - PH : n1;
    p2 = n2 > VA - PH ? VA - PH : n2;
  endfunction
  function automatic bit inr(input int v, input int lo, input int n);
    return v >= lo && v < lo + n;
  endfunction
  function automatic bit pix_model(input int x, input int y);
    return (ms != GAME_OVER && inr(x, bx, BS) && inr(y, by, BS)) ||
           (inr(x, P1X, PW) && inr(y, p1, PH)) || (inr(x, P2X, PW) && inr(y, p2, PH)) ||
           (inr(x, NX, 3) && (y / 8) % 2 == 0);
  endfunction
  // 0 random, 1 follow the ball, 2 stay clear of the ball, 3 beyond the clamp limit
  function automatic int paddle_pick(input int mode);
    int t;
    case (mode)
      1: begin t = by - 22 + int'($urandom_range(0, 20)) - 10; return t < 0 ? 0 : t; end
      2: return by < VA / 2 ? 430 + int'($urandom_range(0, 40)) : int'($urandom_range(0, 184));
      3: return 470;
      default: return int'($urandom_range(0, 511));
    endcase
  endfunction
  task automatic pixel_check();
    int x, y;
    bit d, want;
    case ($urandom_range(0, 4))
      0: begin x = bx + int'($urandom_range(0, 9)) - 2; y = by + int'($urandom_range(0, 9)) - 2; end
      1: begin x = P1X + int'($urandom_range(0, 9)) - 2; y = p1 + int'($urandom_range(0, 55)) - 2; end
      2: begin x = P2X + int'($urandom_range(0, 9)) - 2; y = p2 + int'($urandom_range(0, 55)) - 2; end
      3: begin x = NX + int'($urandom_range(0, 5)) - 1; y = int'($urandom_range(0, VA - 1)); end
      default: begin x = int'($urandom_range(0, HA - 1)); y = int'($urandom_range(0, VA - 1)); end
    endcase
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    d = $urandom_range(0, 7) != 0;
    @(negedge clk);
    hpos = 10'(x); vpos = 10'(y); de = d;
    @(negedge clk);
    want = d && pix_model(x, y);
    vectors++;
    if ({r, g, b} !== {3{want}})
      begin errors++; $display("FAIL pixel (%0d,%0d,de=%0b): got rgb=%b%b%b want %0b", x, y, d, r, g, b, want); end
  endtask
  task automatic frame(input int m1, input int m2, input bit st);
    int n1, n2;
    n1 = paddle_pick(m1);
    n2 = paddle_pick(m2);
    @(negedge clk);
    paddle1_next = 10'(n1); paddle2_next = 10'(n2); start = st; vsync = 1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    vsync = 0; start = 0;
    model_tick(n1, n2, st);
    vectors++;
    if (dut.state !== ms) begin errors++; $display("FAIL frame state: got %0d want %0d", dut.state, ms); end
    vectors++;
    if (game_over !== (ms == GAME_OVER))
      begin errors++; $display("FAIL frame game_over: got %0b want %0b", game_over, ms == GAME_OVER); end
    vectors++;
    if (int'(score1) != s1 || int'(score2) != s2)
      begin errors++; $display("FAIL frame scores: got %0d/%0d want %0d/%0d", score1, score2, s1, s2); end
    vectors++;
    if (int'(dut.paddle1_vpos) != p1 || int'(dut.paddle2_vpos) != p2)
      begin errors++; $display("FAIL frame paddles: got %0d/%0d want %0d/%0d", dut.paddle1_vpos, dut.paddle2_vpos, p1, p2); end
    if (ms == SERVE || ms == PLAY) begin
      vectors++;
      if (int'(dut.ball_hpos) != bx || int'(dut.ball_vpos) != by || dut.dir_h != dh || dut.dir_v != dv)
        begin errors++; $display("FAIL frame ball: got (%0d,%0d) dir %0b%0b want (%0d,%0d) dir %0b%0b",
          dut.ball_hpos, dut.ball_vpos, dut.dir_h, dut.dir_v, bx, by, dh, dv); end
    end
    repeat (2) pixel_check();
  endtask
  task automatic test_reset();
    reset = 1; hpos = 322; vpos = 242; de = 1; vsync = 0;
    repeat (3) @(negedge clk);
    model_reset();
    vectors++;
    if (r !== 1'b0 || dut.state !== SERVE || int'(dut.ball_hpos) != 320 || int'(dut.ball_vpos) != 240 || score1 !== 0)
      begin errors++; $display("FAIL reset_values: got r=%0b state=%0d ball=(%0d,%0d) s1=%0d want 0,SERVE,(320,240),0",
        r, dut.state, dut.ball_hpos, dut.ball_vpos, score1); end
    reset = 0;
    frame(0, 0, 0);
  endtask
  task automatic test_serve();
    for (int i = 2; i < SERVE_N; i++) frame(0, 0, 1'($urandom_range(0, 1)));
    vectors++;
    if (dut.state !== SERVE) begin errors++; $display("FAIL serve_hold: got %0d want SERVE", dut.state); end
    frame(0, 0, 0);
    vectors++;
    if (dut.state !== PLAY) begin errors++; $display("FAIL serve_release: got %0d want PLAY", dut.state); end
    frame(0, 0, 0);
    vectors++;
    if (int'(dut.ball_hpos) != 324 || int'(dut.ball_vpos) != 244)
      begin errors++; $display("FAIL first_move: got (%0d,%0d) want (324,244)", dut.ball_hpos, dut.ball_vpos); end
  endtask
  task automatic test_bounce();
    int n = 0;
    while (!(by == 472 && dv) && n < 200) begin frame(0, 0, 0); n++; end
    vectors++;
    if (n == 200) begin errors++; $display("FAIL bounce_setup: got timeout want vpos 472"); end
    frame(0, 0, 0);
    vectors++;
    if (int'(dut.ball_vpos) != 474 || dut.dir_v !== 1'b0)
      begin errors++; $display("FAIL bottom_bounce: got vpos %0d dir_v %0b want 474 0", dut.ball_vpos, dut.dir_v); end
    frame(0, 0, 0);
    vectors++;
    if (int'(dut.ball_vpos) != 470)
      begin errors++; $display("FAIL after_bounce: got vpos %0d want 470", dut.ball_vpos); end
  endtask
  task automatic test_hit();
    int n = 0;
    while (dh && n < 300) begin frame(0, 1, 0); n++; end
    vectors++;
    if (int'(dut.ball_hpos) != 616 || dut.dir_h !== 1'b0)
      begin errors++; $display("FAIL right_hit: got hpos %0d dir_h %0b want 616 0", dut.ball_hpos, dut.dir_h); end
    n = 0;
    while (!dh && n < 300) begin frame(1, 0, 0); n++; end
    vectors++;
    if (int'(dut.ball_hpos) != 20 || dut.dir_h !== 1'b1)
      begin errors++; $display("FAIL left_hit: got hpos %0d dir_h %0b want 20 1", dut.ball_hpos, dut.dir_h); end
  endtask
  task automatic test_miss();
    int n = 0;
    while (ms != POINT && n < 400) begin frame(2, 1, 0); n++; end
    vectors++;
    if (dut.state !== POINT || score2 !== 4'd1 || score1 !== 4'd0)
      begin errors++; $display("FAIL left_miss: got state %0d scores %0d/%0d want POINT 0/1", dut.state, score1, score2); end
    frame(2, 1, 0);
    vectors++;
    if (dut.state !== SERVE || dut.dir_h !== 1'b0 || int'(dut.ball_hpos) != 320)
      begin errors++; $display("FAIL after_point: got state %0d dir_h %0b hpos %0d want SERVE 0 320", dut.state, dut.dir_h, dut.ball_hpos); end
  endtask
  task automatic test_game_over();
    int n = 0;
    while (!(ms == POINT && s1 == SMAX) && n < 3000) begin frame(1, 2, 0); n++; end
    vectors++;
    if (score1 !== 4'd9 || game_over !== 1'b0)
      begin errors++; $display("FAIL winning_point: got score1 %0d game_over %0b want 9 0", score1, game_over); end
    frame(1, 2, 0);
    vectors++;
    if (game_over !== 1'b1 || dut.state !== GAME_OVER)
      begin errors++; $display("FAIL game_over: got %0b state %0d want 1 GAME_OVER", game_over, dut.state); end
    @(negedge clk);
    hpos = 10'(bx + 2); vpos = 10'(by + 2); de = 1;
    @(negedge clk);
    vectors++;
    if (r !== 1'b0) begin errors++; $display("FAIL hidden_ball: got r=%0b want 0", r); end
    repeat (3) frame(0, 0, 0);
    vectors++;
    if (dut.state !== GAME_OVER || score1 !== 4'd9)
      begin errors++; $display("FAIL frozen: got state %0d score1 %0d want GAME_OVER 9", dut.state, score1); end
    frame(0, 0, 1);
    vectors++;
    if (dut.state !== SERVE || score1 !== 0 || score2 !== 0 || dut.dir_h !== 1'b1 || int'(dut.ball_hpos) != 320)
      begin errors++; $display("FAIL restart: got state %0d scores %0d/%0d dir_h %0b hpos %0d want SERVE 0/0 1 320",
        dut.state, score1, score2, dut.dir_h, dut.ball_hpos); end
  endtask
  task automatic test_clamp();
    frame(3, 3, 0);
    vectors++;
    if (int'(dut.paddle1_vpos) != 430 || int'(dut.paddle2_vpos) != 430)
      begin errors++; $display("FAIL clamp: got %0d/%0d want 430/430", dut.paddle1_vpos, dut.paddle2_vpos); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    while (!(ms == PLAY && s1 + s2 > 0) && n < 1500) begin frame(2, 2, 0); n++; end
    repeat (3) frame(2, 2, 0);
    vectors++;
    if (dut.state !== PLAY) begin errors++; $display("FAIL mid_setup: got state %0d want PLAY", dut.state); end
    @(negedge clk);
    reset = 1; hpos = 321; vpos = 0; de = 1;
    @(negedge clk);
    vectors++;
    if (dut.state !== SERVE || score1 !== 0 || score2 !== 0 || game_over !== 0 || r !== 0 ||
        int'(dut.ball_hpos) != 320 || int'(dut.ball_vpos) != 240 || dut.dir_h !== 1 || dut.dir_v !== 1 ||
        dut.paddle1_vpos !== 0 || dut.paddle2_vpos !== 0)
      begin errors++; $display("FAIL mid_reset: got state %0d scores %0d/%0d go %0b r %0b ball (%0d,%0d) want reset values",
        dut.state, score1, score2, game_over, r, dut.ball_hpos, dut.ball_vpos); end
    reset = 0;
    model_reset();
    repeat (3) frame(0, 0, 0);
  endtask
  initial begin
    model_reset();
    test_reset();
    test_serve();
    test_bounce();
    test_hit();
    test_miss();
    test_game_over();
    test_clamp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
